// File: rtl/pipelined_adder_pkg.sv
// Shared types and constants for the pipelined adder: default datapath width,
// add/subtract mode encoding and the signed saturation limits.
package pipelined_adder_pkg;

    localparam int DATA_WIDTH = 16;

    // Saturation limits are built in a wide vector and sliced by the user.
    localparam int SAT_VEC_W = 64;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic logic [SAT_VEC_W-1:0] sat_max(input int w);
        return (SAT_VEC_W'(1) << (w - 1)) - SAT_VEC_W'(1);
    endfunction

    function automatic logic [SAT_VEC_W-1:0] sat_min(input int w);
        return SAT_VEC_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry slice of the pipelined adder: a W-bit ripple add with carry in
// and carry out, purely combinational.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum   = total[W-1:0];
    assign cout  = total[W];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-split pipelined adder/subtractor with valid/ready handshake, global
// freeze, signed overflow detection and optional signed saturation.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DATA_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int WS  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    localparam logic [SAT_VEC_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [SAT_VEC_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_MAX_W    = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_MIN_W    = SAT_MIN_FULL[WIDTH-1:0];

    mode_e mode;
    logic  advance;

    // Inputs seen by each stage's slice adder.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];
    logic             sat_in [STAGES];

    logic [WS-1:0]    slice_sum  [STAGES];
    logic             slice_cout [STAGES];
    logic [WIDTH-1:0] s_next     [STAGES];

    // Registered state at the output of each stage.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             sat_q [STAGES];

    logic [WIDTH-1:0] raw;
    logic             a_msb;
    logic             b_msb;
    logic             raw_ovf;

    assign mode     = sub ? MODE_SUB : MODE_ADD;
    assign advance  = enable & (~out_valid | out_ready);
    assign in_ready = advance;

    // Stage 0 takes the operand beat directly; later stages take the
    // previous stage register. B is inverted once here so sub travels as B'.
    always_comb begin
        a_in[0]   = op1;
        b_in[0]   = (mode == MODE_SUB) ? ~op2 : op2;
        s_in[0]   = '0;
        c_in[0]   = cin;
        v_in[0]   = in_valid & advance;
        sat_in[0] = sat;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            c_in[k]   = c_q[k-1];
            v_in[k]   = v_q[k-1];
            sat_in[k] = sat_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .W(WS)
        ) u_slice (
            .a   (a_in[k][k*WS +: WS]),
            .b   (b_in[k][k*WS +: WS]),
            .cin (c_in[k]),
            .sum (slice_sum[k]),
            .cout(slice_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next[k]              = s_in[k];
            s_next[k][k*WS +: WS]  = slice_sum[k];
        end
    end

    // The whole pipe moves together on advance; data registers only load
    // for valid beats so bubbles never disturb the last stage's outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k]   <= a_in[k];
                    b_q[k]   <= b_in[k];
                    s_q[k]   <= s_next[k];
                    c_q[k]   <= slice_cout[k];
                    sat_q[k] <= sat_in[k];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign raw       = s_q[STAGES-1];
    assign a_msb     = a_q[STAGES-1][MSB];
    assign b_msb     = b_q[STAGES-1][MSB];
    assign raw_ovf   = (a_msb == b_msb) & (raw[MSB] != a_msb);

    assign cout   = c_q[STAGES-1];
    assign ovf    = raw_ovf;
    assign result = (sat_q[STAGES-1] & raw_ovf) ? (a_msb ? SAT_MIN_W : SAT_MAX_W) : raw;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, a
// backpressure/freeze stream, async reset mid-flight and random traffic.
module tb_pipelined_adder;

    localparam int W    = 16;
    localparam int S    = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         cin;
    logic         sub;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           acc_cycle;
    } exp_t;

    exp_t sb_q[$];

    int           tests = 0;
    int           failures = 0;
    int           cycle = 0;
    int           outputs_seen = 0;
    bit           check_lat = 1'b0;
    bit           accepted = 1'b0;
    bit           hold_prev = 1'b0;
    logic [W-1:0] held_res;
    logic         held_cout;
    logic         held_ovf;
    logic [W-1:0] last_res;
    logic         last_cout;
    logic         last_ovf;

    pipelined_adder #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op1      (op1),
        .op2      (op2),
        .cin      (cin),
        .sub      (sub),
        .sat      (sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    // Reference: two's-complement arithmetic on plain integers.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s, input logic st,
                                   input int acc);
        exp_t e;
        int ua, ub, total, sa, sbv, ssum;
        ua    = int'(a);
        ub    = s ? (MOD - 1 - int'(b)) : int'(b);
        total = ua + ub + int'(c);
        sa    = (ua >= HALF) ? ua - MOD : ua;
        sbv   = (ub >= HALF) ? ub - MOD : ub;
        ssum  = sa + sbv + int'(c);
        e.co  = (total >= MOD);
        e.ov  = (ssum >= HALF) || (ssum < -HALF);
        if (st && e.ov)
            e.res = (ssum > 0) ? W'(HALF - 1) : W'(HALF);
        else
            e.res = W'(total % MOD);
        e.acc_cycle = acc;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock cycle: observe handshakes shortly after inputs change at the
    // falling edge, then wait for the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        accepted = 1'b0;
        if (reset_n) begin
            checkOutput("in_ready", 32'(in_ready), 32'(enable && (!out_valid || out_ready)));
            if (hold_prev) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_result", 32'(result), 32'(held_res));
                checkOutput("hold_flags", 32'({cout, ovf}), 32'({held_cout, held_ovf}));
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(op1, op2, cin, sub, sat, cycle));
                accepted = 1'b1;
            end
            if (out_valid && out_ready && enable) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("cout", 32'(cout), 32'(e.co));
                    checkOutput("ovf", 32'(ovf), 32'(e.ov));
                    if (check_lat)
                        checkOutput("latency", 32'(cycle - e.acc_cycle), 32'(S));
                    last_res  = result;
                    last_cout = cout;
                    last_ovf  = ovf;
                    outputs_seen++;
                end
            end
            hold_prev = out_valid && !(out_ready && enable);
            held_res  = result;
            held_cout = cout;
            held_ovf  = ovf;
        end else begin
            hold_prev = 1'b0;
        end
        @(negedge clock);
        cycle++;
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s, input logic st,
                                 input logic [W-1:0] exp_res, input logic exp_cout,
                                 input logic exp_ovf);
        int n0;
        op1      = a;
        op2      = b;
        cin      = c;
        sub      = s;
        sat      = st;
        in_valid = 1'b1;
        n0       = outputs_seen;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && outputs_seen == n0; i++) tick();
        checkOutput({tag, "_arrived"}, 32'(outputs_seen - n0), 32'd1);
        checkOutput({tag, "_result"}, 32'(last_res), 32'(exp_res));
        checkOutput({tag, "_cout"}, 32'(last_cout), 32'(exp_cout));
        checkOutput({tag, "_ovf"}, 32'(last_ovf), 32'(exp_ovf));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] edge_vals [5];
        int idx;
        int recv_start;
        edge_vals = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

        reset_n   = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op1       = '0;
        op2       = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        sat       = 1'b0;

        @(negedge clock);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("in_reset_valid", 32'(out_valid), 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_result", 32'(result), 32'h0000);
        checkOutput("idle_flags", 32'({cout, ovf}), 32'd0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        tick();

        check_lat = 1'b1;
        applyStimulus("carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        applyStimulus("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus("ovf_nosat", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus("ovf_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        applyStimulus("sub_neg", 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus("sub_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);

        check_lat  = 1'b0;
        idx        = 0;
        recv_start = outputs_seen;
        cin = 1'b0;
        sub = 1'b0;
        sat = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 8 && c < 11);
            enable    = !(c >= 14 && c < 16);
            in_valid  = (idx < 16);
            op1       = W'(idx);
            op2       = W'(idx * 256);
            tick();
            if (accepted) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b1;
        checkOutput("stream_count", 32'(outputs_seen - recv_start), 32'd16);
        checkOutput("stream_pending", 32'(sb_q.size()), 32'd0);

        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op1      = W'($urandom);
            op2      = W'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("async_reset_result", 32'(result), 32'h0000);
        sb_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("no_stale_beat", 32'(out_valid), 32'd0);
            tick();
        end
        applyStimulus("post_reset", 16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h2346, 1'b0, 1'b0);

        check_lat = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 8);
            enable    = ($urandom_range(0, 9) < 9);
            op1 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            op2 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            sat = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
        checkOutput("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
